// File: rtl/sha_block_loader_pkg.sv
// Shared widths, defaults and FSM encoding for the SHA block loader slice.
// No logic; constants and types only.
// Imported by the loader top and its beat buffer.
package sha_block_loader_pkg;

    localparam int BLOCK_W         = 512;
    localparam int DIGEST_W        = 256;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/sha_block_loader_beat_buffer.sv
// Indexed 512-bit message register; beat idx lands at the idx-th slice from the MSB end.
// Latency: a loaded beat is visible on block the cycle after load.
// No backpressure: the owner decides when load may assert.
module sha_block_loader_beat_buffer
    import sha_block_loader_pkg::*;
#(
    parameter int BEAT_W = 128,
    parameter int BEATS  = 4,
    parameter int IW     = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic [IW-1:0]      idx,
    input  logic [BEAT_W-1:0]  beat,
    output logic [BLOCK_W-1:0] block
);

    // Store the incoming beat into its slice; first beat occupies the MS bits.
    always_ff @(posedge clk) begin
        if (!clr) begin
            block <= '0;
        end else if (load) begin
            for (int b = 0; b < BEATS; b++) begin
                if (int'(idx) == b) begin
                    block[BLOCK_W-1-b*BEAT_W -: BEAT_W] <= beat;
                end
            end
        end
    end

endmodule

// File: rtl/sha_block_loader.sv
// Sequences one 512-bit block into sha_core, times out the wait, holds the digest for the host.
// Latency: last beat cycle N -> core_start N+1; core_valid cycle M -> digest_valid M+1.
// Backpressure: wr_ready only in FILL; beats offered otherwise are dropped, digest held until rd_ack.
module sha_block_loader
    import sha_block_loader_pkg::*;
#(
    parameter int BEAT_W  = 128,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [BEAT_W-1:0]   wr_data,
    output logic                wr_ready,
    input  logic                rd_ack,
    input  logic                abort,
    output logic                core_clr,
    output logic                core_start,
    output logic [BLOCK_W-1:0]  core_message,
    input  logic [DIGEST_W-1:0] core_hash,
    input  logic                core_valid,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy,
    output logic                error
);

    // BEAT_W*BEATS is expected to equal BLOCK_W; index/timer sized from the parameters.
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  timer;
    logic           clr_pulse;
    logic           beat_load;

    // Abort drops a coincident beat so the restarted block starts clean.
    assign beat_load = wr_en && wr_ready && !abort;

    // The core is held in reset with ours, and kicked for one cycle on abort or timeout.
    assign core_clr = clr & ~clr_pulse;

    sha_block_loader_beat_buffer #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS),
        .IW     (IW)
    ) u_beat_buffer (
        .clk   (clk),
        .clr   (clr),
        .load  (beat_load),
        .idx   (idx),
        .beat  (wr_data),
        .block (core_message)
    );

    // Control FSM; all outputs registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state        <= ST_FILL;
            idx          <= '0;
            timer        <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            error        <= 1'b0;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            wr_ready     <= 1'b1;
            clr_pulse    <= 1'b0;
        end else begin
            clr_pulse  <= 1'b0;
            core_start <= 1'b0;
            if (abort) begin
                state        <= ST_FILL;
                idx          <= '0;
                error        <= 1'b0;
                digest_valid <= 1'b0;
                busy         <= 1'b0;
                wr_ready     <= 1'b1;
                clr_pulse    <= 1'b1;
            end else begin
                case (state)
                    ST_FILL: begin
                        if (wr_en && wr_ready) begin
                            if (idx == IW'(BEATS - 1)) begin
                                idx        <= '0;
                                state      <= ST_START;
                                core_start <= 1'b1;
                                busy       <= 1'b1;
                                wr_ready   <= 1'b0;
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end
                    end
                    ST_START: begin
                        state <= ST_WAIT;
                        timer <= '0;
                    end
                    ST_WAIT: begin
                        // A result arriving on the timeout cycle still counts.
                        if (core_valid) begin
                            digest       <= core_hash;
                            digest_valid <= 1'b1;
                            busy         <= 1'b0;
                            state        <= ST_DONE;
                        end else if (timer == TW'(TIMEOUT)) begin
                            error     <= 1'b1;
                            busy      <= 1'b0;
                            clr_pulse <= 1'b1;
                            state     <= ST_ERR;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_DONE: begin
                        if (rd_ack) begin
                            digest_valid <= 1'b0;
                            wr_ready     <= 1'b1;
                            state        <= ST_FILL;
                        end
                    end
                    ST_ERR: begin
                        state <= ST_ERR;
                    end
                    default: begin
                        state    <= ST_FILL;
                        idx      <= '0;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha_block_loader.sv
module tb_sha_block_loader;

    localparam int BEAT_W  = 128;
    localparam int BEATS   = 4;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         clr;
    logic         wr_en;
    logic [127:0] wr_data;
    logic         wr_ready;
    logic         rd_ack;
    logic         abort;
    logic         core_clr;
    logic         core_start;
    logic [511:0] core_message;
    logic [255:0] core_hash;
    logic         core_valid;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    logic         error;

    int n_checks = 0;
    int n_fails  = 0;

    logic [511:0] abc_blk;
    logic [511:0] blk2;
    logic [511:0] blk3;
    logic [255:0] abc_dig;
    logic [255:0] h2;
    logic [255:0] h_junk;

    always #5 clk = ~clk;

    sha_block_loader #(
        .BEAT_W  (BEAT_W),
        .BEATS   (BEATS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_ack       (rd_ack),
        .abort        (abort),
        .core_clr     (core_clr),
        .core_start   (core_start),
        .core_message (core_message),
        .core_hash    (core_hash),
        .core_valid   (core_valid),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy),
        .error        (error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [127:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic send_block(input logic [511:0] b);
        send_beat(b[511:384]);
        send_beat(b[383:256]);
        send_beat(b[255:128]);
        send_beat(b[127:0]);
    endtask

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        blk2    = {128'h00112233445566778899aabbccddeeff, 128'h0123456789abcdeffedcba9876543210,
                   128'hcafef00dcafef00dcafef00dcafef00d, 128'h5555aaaa5555aaaa5555aaaa5555aaaa};
        blk3    = {128'h11111111111111111111111111111111, 128'h22222222222222222222222222222222,
                   128'h33333333333333333333333333333333, 128'h44444444444444444444444444444444};
        abc_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        h2      = 256'h0f0e0d0c0b0a09080706050403020100fedcba9876543210deadbeefc0ffee11;
        h_junk  = 256'hffffffff00000000ffffffff00000000ffffffff00000000ffffffff00000000;

        clr = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ack = 1'b0;
        abort = 1'b0; core_valid = 1'b0; core_hash = '0;

        // Reset state
        step(); step();
        chk1("rst_wr_ready", wr_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_digest_valid", digest_valid, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk1("rst_core_start", core_start, 1'b0);
        chk1("rst_core_clr", core_clr, 1'b0);
        chk256("rst_digest", digest, 256'h0);
        chk512("rst_message", core_message, 512'h0);
        clr = 1'b1;
        step();
        chk1("run_core_clr", core_clr, 1'b1);

        // "abc" block: start one cycle after the last beat
        send_beat(abc_blk[511:384]);
        send_beat(abc_blk[383:256]);
        chk1("abc_mid_ready", wr_ready, 1'b1);
        chk1("abc_mid_start", core_start, 1'b0);
        send_beat(abc_blk[255:128]);
        chk1("abc_b3_start", core_start, 1'b0);
        send_beat(abc_blk[127:0]);
        chk1("abc_start", core_start, 1'b1);
        chk1("abc_busy", busy, 1'b1);
        chk1("abc_ready_low", wr_ready, 1'b0);
        chk512("abc_message", core_message, abc_blk);
        wr_en = 1'b1; wr_data = '1;
        step();
        chk1("start_one_cycle", core_start, 1'b0);
        chk1("wait_busy", busy, 1'b1);
        step();
        chk512("wait_wr_ignored", core_message, abc_blk);
        wr_en = 1'b0; wr_data = '0;
        core_valid = 1'b1; core_hash = abc_dig;
        step();
        core_valid = 1'b0;
        chk1("abc_digest_valid", digest_valid, 1'b1);
        chk256("abc_digest", digest, abc_dig);
        chk1("done_busy", busy, 1'b0);
        chk1("done_ready", wr_ready, 1'b0);

        // DONE holds: writes and stray core_valid ignored
        wr_en = 1'b1; wr_data = '1; core_valid = 1'b1; core_hash = h_junk;
        step(); step();
        wr_en = 1'b0; wr_data = '0; core_valid = 1'b0;
        chk512("done_msg_hold", core_message, abc_blk);
        chk256("done_digest_hold", digest, abc_dig);
        chk1("done_valid_hold", digest_valid, 1'b1);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        chk1("ack_valid_clr", digest_valid, 1'b0);
        chk1("ack_ready", wr_ready, 1'b1);

        // Back-to-back block; core_valid on the timeout cycle wins
        send_block(blk2);
        chk1("b2_start", core_start, 1'b1);
        chk512("b2_message", core_message, blk2);
        repeat (17) step();
        chk1("edge_no_error", error, 1'b0);
        chk1("edge_busy", busy, 1'b1);
        core_valid = 1'b1; core_hash = h2;
        step();
        core_valid = 1'b0;
        chk1("edge_digest_valid", digest_valid, 1'b1);
        chk256("edge_digest", digest, h2);
        chk1("edge_error_low", error, 1'b0);
        chk1("edge_core_clr", core_clr, 1'b1);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;

        // Timeout: error 18 cycles after core_start
        send_block(blk2);
        chk1("to_start", core_start, 1'b1);
        repeat (17) step();
        chk1("to_pre_error", error, 1'b0);
        chk1("to_pre_core_clr", core_clr, 1'b1);
        step();
        chk1("to_error", error, 1'b1);
        chk1("to_core_clr_low", core_clr, 1'b0);
        chk1("to_ready", wr_ready, 1'b0);
        chk1("to_busy", busy, 1'b0);
        wr_en = 1'b1; wr_data = '1;
        step();
        wr_en = 1'b0; wr_data = '0;
        chk1("err_core_clr_back", core_clr, 1'b1);
        chk1("err_sticky", error, 1'b1);
        chk1("err_ready", wr_ready, 1'b0);
        chk512("err_msg_hold", core_message, blk2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk1("abort_err_clear", error, 1'b0);
        chk1("abort_err_ready", wr_ready, 1'b1);
        chk1("abort_err_core_clr", core_clr, 1'b0);
        step();
        chk1("abort_core_clr_back", core_clr, 1'b1);

        // core_valid in FILL ignored
        core_valid = 1'b1; core_hash = h_junk;
        step();
        core_valid = 1'b0;
        chk1("fill_valid_ignored", digest_valid, 1'b0);

        // Abort after two beats, coincident beat dropped, index restarts
        send_beat(128'hdead0000dead0000dead0000dead0000);
        send_beat(128'hbeef0000beef0000beef0000beef0000);
        wr_en = 1'b1; wr_data = 128'h99999999999999999999999999999999; abort = 1'b1;
        step();
        wr_en = 1'b0; wr_data = '0; abort = 1'b0;
        chk1("abort_fill_ready", wr_ready, 1'b1);
        chk1("abort_fill_core_clr", core_clr, 1'b0);
        send_beat(blk3[511:384]);
        send_beat(blk3[383:256]);
        chk1("b3_two_no_start", core_start, 1'b0);
        send_beat(blk3[255:128]);
        chk1("b3_three_no_start", core_start, 1'b0);
        send_beat(blk3[127:0]);
        chk1("b3_start", core_start, 1'b1);
        chk512("b3_message", core_message, blk3);

        // Abort beats a coincident core_valid
        step();
        core_valid = 1'b1; core_hash = h_junk; abort = 1'b1;
        step();
        core_valid = 1'b0; abort = 1'b0;
        chk1("abort_valid_dv", digest_valid, 1'b0);
        chk256("abort_valid_digest", digest, h2);
        chk1("abort_valid_ready", wr_ready, 1'b1);
        chk1("abort_valid_busy", busy, 1'b0);

        // Reset mid-WAIT
        send_block(blk3);
        step(); step();
        chk1("midwait_busy", busy, 1'b1);
        clr = 1'b0;
        #1;
        chk1("midwait_core_clr_comb", core_clr, 1'b0);
        step();
        chk1("mrst_wr_ready", wr_ready, 1'b1);
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_digest_valid", digest_valid, 1'b0);
        chk1("mrst_error", error, 1'b0);
        chk1("mrst_core_start", core_start, 1'b0);
        chk1("mrst_core_clr", core_clr, 1'b0);
        chk256("mrst_digest", digest, 256'h0);
        chk512("mrst_message", core_message, 512'h0);
        clr = 1'b1;
        step();
        chk1("mrst_core_clr_back", core_clr, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
